// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - tile sequencer for the double-buffered accumulator memory
// Turns tile commands and the psum_valid stream into enable/mode/buffer controls.
module accum_ctrl #(
    parameter int K_W   = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [K_W-1:0]   cmd_k,
    input  logic             psum_valid,
    output logic             acc_enable,
    output logic             acc_mode,
    output logic             acc_buf_sel,
    output logic [1:0]       buf_full,
    input  logic [1:0]       buf_release,
    output logic             tile_done,
    output logic             tile_done_buf,
    output logic [CNT_W-1:0] tile_count,
    output logic             err_overrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUF = 2'd1,
        ACCUM    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             wr_buf_q, wr_buf_d;
    logic [K_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [K_W-1:0]   k_reg_q, k_reg_d;
    logic [1:0]       buf_full_q, buf_full_d;
    logic             tile_done_q, tile_done_d;
    logic             tile_done_buf_q, tile_done_buf_d;
    logic [CNT_W-1:0] tile_count_q, tile_count_d;
    logic             err_overrun_q, err_overrun_d;
    logic             mode_hold_q, mode_hold_d;
    logic             sel_hold_q, sel_hold_d;
    logic             in_accum;
    logic             last_beat;

    assign in_accum  = (state_q == ACCUM);
    assign last_beat = in_accum && psum_valid && (beat_cnt_q == k_reg_q - K_W'(1));

    always_comb begin
        state_d         = state_q;
        wr_buf_d        = wr_buf_q;
        beat_cnt_d      = beat_cnt_q;
        k_reg_d         = k_reg_q;
        tile_done_d     = 1'b0;
        tile_done_buf_d = tile_done_buf_q;
        tile_count_d    = tile_count_q;
        err_overrun_d   = err_overrun_q;
        mode_hold_d     = mode_hold_q;
        sel_hold_d      = sel_hold_q;
        // Release is applied first so a forced same-buffer set below wins.
        buf_full_d      = buf_full_q & ~buf_release;

        if (psum_valid && !in_accum) begin
            err_overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    k_reg_d    = (cmd_k == '0) ? K_W'(1) : cmd_k;
                    beat_cnt_d = '0;
                    state_d    = buf_full_q[wr_buf_q] ? WAIT_BUF : ACCUM;
                end
            end
            WAIT_BUF: begin
                if (!buf_full_q[wr_buf_q] || buf_release[wr_buf_q]) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                mode_hold_d = (beat_cnt_q != '0);
                sel_hold_d  = wr_buf_q;
                if (last_beat) begin
                    beat_cnt_d           = '0;
                    buf_full_d[wr_buf_q] = 1'b1;
                    tile_done_d          = 1'b1;
                    tile_done_buf_d      = wr_buf_q;
                    tile_count_d         = tile_count_q + CNT_W'(1);
                    wr_buf_d             = ~wr_buf_q;
                    state_d              = IDLE;
                end else if (psum_valid) begin
                    beat_cnt_d = beat_cnt_q + K_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_buf_q        <= 1'b0;
            beat_cnt_q      <= '0;
            k_reg_q         <= K_W'(1);
            buf_full_q      <= 2'b00;
            tile_done_q     <= 1'b0;
            tile_done_buf_q <= 1'b0;
            tile_count_q    <= '0;
            err_overrun_q   <= 1'b0;
            mode_hold_q     <= 1'b0;
            sel_hold_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_buf_q        <= wr_buf_d;
            beat_cnt_q      <= beat_cnt_d;
            k_reg_q         <= k_reg_d;
            buf_full_q      <= buf_full_d;
            tile_done_q     <= tile_done_d;
            tile_done_buf_q <= tile_done_buf_d;
            tile_count_q    <= tile_count_d;
            err_overrun_q   <= err_overrun_d;
            mode_hold_q     <= mode_hold_d;
            sel_hold_q      <= sel_hold_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign acc_enable    = in_accum && psum_valid;
    assign acc_mode      = in_accum ? (beat_cnt_q != '0) : mode_hold_q;
    assign acc_buf_sel   = in_accum ? wr_buf_q : sel_hold_q;
    assign buf_full      = buf_full_q;
    assign tile_done     = tile_done_q;
    assign tile_done_buf = tile_done_buf_q;
    assign tile_count    = tile_count_q;
    assign err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - directed vector bench for accum_ctrl
module tb_accum_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_k;
    logic        psum_valid;
    logic        acc_enable;
    logic        acc_mode;
    logic        acc_buf_sel;
    logic [1:0]  buf_full;
    logic [1:0]  buf_release;
    logic        tile_done;
    logic        tile_done_buf;
    logic [15:0] tile_count;
    logic        err_overrun;

    int tests  = 0;
    int failed = 0;

    accum_ctrl #(.K_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .psum_valid(psum_valid),
        .acc_enable(acc_enable), .acc_mode(acc_mode), .acc_buf_sel(acc_buf_sel),
        .buf_full(buf_full), .buf_release(buf_release),
        .tile_done(tile_done), .tile_done_buf(tile_done_buf),
        .tile_count(tile_count), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] k;
        logic       pv;
        logic [1:0] rel;
        logic       en;
        logic       mode;
        logic       sel;
        logic       rdy;
        logic [1:0] full;
        logic       td;
        logic       tdb;
        int         cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cv, logic [7:0] k, logic pv, logic [1:0] rel,
                                logic en, logic mode, logic sel, logic rdy,
                                logic [1:0] full, logic td, logic tdb, int cnt, logic err);
        vec_t v;
        v.cv = cv; v.k = k; v.pv = pv; v.rel = rel;
        v.en = en; v.mode = mode; v.sel = sel; v.rdy = rdy;
        v.full = full; v.td = td; v.tdb = tdb; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [7:0] k, input logic pv, input logic [1:0] rel);
        cmd_valid = cv; cmd_k = k; psum_valid = pv; buf_release = rel;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("acc_enable", idx, int'(acc_enable), int'(v.en));
        if (v.en) begin
            chk("acc_mode", idx, int'(acc_mode), int'(v.mode));
            chk("acc_buf_sel", idx, int'(acc_buf_sel), int'(v.sel));
        end
        chk("cmd_ready", idx, int'(cmd_ready), int'(v.rdy));
        chk("buf_full", idx, int'(buf_full), int'(v.full));
        chk("tile_done", idx, int'(tile_done), int'(v.td));
        if (v.td) chk("tile_done_buf", idx, int'(tile_done_buf), int'(v.tdb));
        chk("tile_count", idx, int'(tile_count), v.cnt);
        chk("err_overrun", idx, int'(err_overrun), int'(v.err));
    endtask

    // One vector per cycle: inputs applied after the edge, outputs sampled at negedge.
    task automatic step(input vec_t v, input int idx);
        drive(v.cv, v.k, v.pv, v.rel);
        @(negedge clk);
        check_vec(v, idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        cv  k    pv rel    en mode sel rdy full   td tdb cnt err
        // tile 1: K=3 on buffer 0
        vecs.push_back(mk(1, 8'd3, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0));
        // tile 2: K=2 on buffer 1 while buffer 0 still full
        vecs.push_back(mk(1, 8'd2, 0, 2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 0, 1, 0, 2'b01, 0, 0, 1, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 1, 0, 2'b01, 0, 0, 1, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b11, 1, 1, 2, 0));
        // tile 3: cmd_k=0 with both buffers full -> WAIT_BUF, release buffer 0
        vecs.push_back(mk(1, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b11, 0, 0, 2, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 2, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b01, 0, 0, 0, 0, 2'b11, 0, 0, 2, 0));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 0, 0, 0, 2'b10, 0, 0, 2, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b11, 1, 0, 3, 0));
        // release both, then release of empty buffers is harmless
        vecs.push_back(mk(0, 8'd0, 0, 2'b11, 0, 0, 0, 1, 2'b11, 0, 0, 3, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b01, 0, 0, 0, 1, 2'b00, 0, 0, 3, 0));
        // psum_valid in IDLE: dropped, sticky error
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 3, 0));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 3, 1));
        // tile 4: K=4 on buffer 1 with gaps 1,0,1,1,0,1; a stray command is ignored
        vecs.push_back(mk(1, 8'd4, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 0, 1, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(1, 8'd1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 1, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 1, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 1, 2'b00, 1, 1, 1, 0, 2'b00, 0, 0, 3, 1));
        vecs.push_back(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 1, 1, 4, 1));

        reset = 1'b1;
        drive(0, 8'd0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_vec(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 0);
        chk("rst_tile_done_buf", 0, int'(tile_done_buf), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i + 1);
        end

        // reset mid-tile after 2 of 4 beats, then a K=1 tile lands on buffer 0
        step(mk(1, 8'd4, 0, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0, 4, 1), 100);
        step(mk(0, 8'd0, 1, 2'b00, 1, 0, 0, 0, 2'b10, 0, 0, 4, 1), 101);
        step(mk(0, 8'd0, 1, 2'b00, 1, 1, 0, 0, 2'b10, 0, 0, 4, 1), 102);
        reset = 1'b1;
        drive(0, 8'd0, 0, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_vec(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 103);
        chk("rst2_tile_done_buf", 103, int'(tile_done_buf), 0);
        @(posedge clk);
        #1;
        step(mk(1, 8'd1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 104);
        step(mk(0, 8'd0, 1, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), 105);
        step(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0), 106);
        step(mk(0, 8'd0, 0, 2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0), 107);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
